// File: rtl/sap1_program_loader_if.sv
// rtl/sap1_program_loader_if.sv - byte-source, RAM write port and CPU control bundle for the SAP-1 loader
interface sap1_program_loader_if #(
   parameter int ADDR_W = 4
);
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_data;
   logic              cpu_hold;
   logic              done;
   logic              error;

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, ram_we, ram_addr, ram_data, cpu_hold, done, error
   );

   modport master (
      output start, in_valid, in_data,
      input  in_ready, ram_we, ram_addr, ram_data, cpu_hold, done, error
   );
endinterface

// File: rtl/sap1_program_loader.sv
// rtl/sap1_program_loader.sv - writes a byte-stream image into SAP-1 RAM, holding the CPU in clear until loaded
// Optional trailing checksum byte enabled by SAP1_LOADER_CHECKSUM_EN.
module sap1_program_loader #(
   parameter int ADDR_W = 4,
   parameter int WORDS  = 16
) (
   input  logic                 CLK,
   input  logic                 CLR,
   sap1_program_loader_if.slave bus
);
   localparam int CNT_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2
`ifdef SAP1_LOADER_CHECKSUM_EN
      ,
      CHECK = 3'd3,
      ERROR = 3'd4
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              in_ready_q, in_ready_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]        ram_data_q, ram_data_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              done_q, done_d;
`ifdef SAP1_LOADER_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
   logic              error_q, error_d;
`endif
   logic              accept;
   logic              restart;

   // in_ready is only ever high in LOAD, so it doubles as the state qualifier
   assign accept = bus.in_valid && in_ready_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      in_ready_d = in_ready_q;
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_data_d = ram_data_q;
      cpu_hold_d = cpu_hold_q;
      done_d     = done_q;
      restart    = 1'b0;
`ifdef SAP1_LOADER_CHECKSUM_EN
      sum_d      = sum_q;
      error_d    = error_q;
`endif
      case (state_q)
         IDLE: begin
            cpu_hold_d = 1'b1;
            in_ready_d = 1'b0;
            restart    = bus.start;
         end
         LOAD: begin
            if (accept) begin
               cnt_d = cnt_q + CNT_W'(1);
`ifdef SAP1_LOADER_CHECKSUM_EN
               sum_d = sum_q + bus.in_data;
               if (cnt_q == CNT_W'(WORDS)) begin
                  state_d    = CHECK;
                  in_ready_d = 1'b0;
               end else begin
                  ram_we_d   = 1'b1;
                  ram_addr_d = cnt_q[ADDR_W-1:0];
                  ram_data_d = bus.in_data;
               end
`else
               ram_we_d   = 1'b1;
               ram_addr_d = cnt_q[ADDR_W-1:0];
               ram_data_d = bus.in_data;
               if (cnt_q == CNT_W'(WORDS - 1)) begin
                  state_d    = RUN;
                  in_ready_d = 1'b0;
                  cpu_hold_d = 1'b0;
                  done_d     = 1'b1;
               end
`endif
            end
         end
         RUN: restart = bus.start;
`ifdef SAP1_LOADER_CHECKSUM_EN
         CHECK: begin
            if (sum_q == 8'd0) begin
               state_d    = RUN;
               cpu_hold_d = 1'b0;
               done_d     = 1'b1;
            end else begin
               state_d = ERROR;
               error_d = 1'b1;
            end
         end
         ERROR: restart = bus.start;
`endif
         default: state_d = IDLE;
      endcase

      if (restart) begin
         state_d    = LOAD;
         cnt_d      = '0;
         in_ready_d = 1'b1;
         cpu_hold_d = 1'b1;
         done_d     = 1'b0;
`ifdef SAP1_LOADER_CHECKSUM_EN
         sum_d      = 8'd0;
         error_d    = 1'b0;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         in_ready_q <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_data_q <= 8'd0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
`ifdef SAP1_LOADER_CHECKSUM_EN
         sum_q      <= 8'd0;
         error_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         in_ready_q <= in_ready_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_data_q <= ram_data_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
`ifdef SAP1_LOADER_CHECKSUM_EN
         sum_q      <= sum_d;
         error_q    <= error_d;
`endif
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.ram_we   = ram_we_q;
   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_data = ram_data_q;
   assign bus.cpu_hold = cpu_hold_q;
   assign bus.done     = done_q;
`ifdef SAP1_LOADER_CHECKSUM_EN
   assign bus.error    = error_q;
`else
   assign bus.error    = 1'b0;
`endif
endmodule

// File: tb/tb_sap1_program_loader.sv
// tb/tb_sap1_program_loader.sv - directed self-checking bench for sap1_program_loader
// Checksum steps are built when SAP1_LOADER_CHECKSUM_EN is defined.
module tb_sap1_program_loader;
   logic CLK;
   logic CLR;
   int   n_cmp;
   int   n_err;

`ifdef SAP1_LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   sap1_program_loader_if #(.ADDR_W(4)) lif ();

   sap1_program_loader #(.ADDR_W(4), .WORDS(16)) dut (
      .CLK (CLK),
      .CLR (CLR),
      .bus (lif.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_hold"},  lif.cpu_hold, 1);
      chk({tag, "_done"},  lif.done,     0);
      chk({tag, "_ready"}, lif.in_ready, 0);
      chk({tag, "_we"},    lif.ram_we,   0);
      chk({tag, "_addr"},  lif.ram_addr, 0);
      chk({tag, "_data"},  lif.ram_data, 0);
      chk({tag, "_err"},   lif.error,    0);
   endtask

   // Pulses start, then streams nbytes of base+i*inc. gapped uses the 1,0,0 valid pattern.
   // In checksum builds a full image is followed by its checksum byte (+ck_delta to corrupt it).
   task automatic load_image(input logic [7:0] base, input int inc, input bit gapped,
                             input int nbytes, input logic [7:0] ck_delta);
      int         sent;
      int         cyc;
      bit         v;
      logic [7:0] b;
      logic [7:0] sum;
      sent = 0;
      cyc  = 0;
      sum  = 8'd0;
      lif.start = 1'b1;
      step();
      lif.start = 1'b0;
      chk("start_hold",  lif.cpu_hold, 1);
      chk("start_done",  lif.done,     0);
      chk("start_ready", lif.in_ready, 1);
      chk("start_err",   lif.error,    0);
      while (sent < nbytes && cyc < 200) begin
         v = !gapped || (cyc % 3 == 0);
         b = 8'(int'(base) + sent * inc);
         lif.in_valid = v;
         lif.in_data  = v ? b : 8'hEE;
         step();
         cyc++;
         chk("we", lif.ram_we, 32'(v));
         if (v) begin
            chk("addr", lif.ram_addr, sent[3:0]);
            chk("data", lif.ram_data, b);
            sum  = sum + b;
            sent++;
            if (sent == 16 && !CK) begin
               chk("last_done",  lif.done,     1);
               chk("last_hold",  lif.cpu_hold, 0);
               chk("last_ready", lif.in_ready, 0);
            end else begin
               chk("mid_done",  lif.done,     0);
               chk("mid_hold",  lif.cpu_hold, 1);
               chk("mid_ready", lif.in_ready, 1);
            end
         end
      end
      lif.in_valid = 1'b0;
      chk("load_bytes_sent", sent, nbytes);
      if (CK && nbytes == 16) begin
         lif.in_valid = 1'b1;
         lif.in_data  = 8'(-sum) + ck_delta;
         step();
         lif.in_valid = 1'b0;
         chk("ck_we",    lif.ram_we,   0);
         chk("ck_ready", lif.in_ready, 0);
         chk("ck_done",  lif.done,     0);
         step();
         chk("ck_done2", lif.done,     32'(ck_delta == 0));
         chk("ck_hold2", lif.cpu_hold, 32'(ck_delta != 0));
         chk("ck_err2",  lif.error,    32'(ck_delta != 0));
      end
   endtask

   initial begin
      n_cmp        = 0;
      n_err        = 0;
      CLR          = 1'b1;
      lif.start    = 1'b0;
      lif.in_valid = 1'b0;
      lif.in_data  = 8'h00;
      step();
      step();
      chk_reset_state("reset");
      CLR = 1'b0;
      step();
      chk("idle_hold",  lif.cpu_hold, 1);
      chk("idle_ready", lif.in_ready, 0);

      // full back-to-back image 0x10+i
      load_image(8'h10, 1, 1'b0, 16, 8'h00);
      step();
      chk("run_done", lif.done,     1);
      chk("run_hold", lif.cpu_hold, 0);
      chk("run_we",   lif.ram_we,   0);

      // bytes offered while not ready are ignored and the address does not wrap
      lif.in_valid = 1'b1;
      lif.in_data  = 8'hAA;
      step();
      step();
      lif.in_valid = 1'b0;
      chk("ignored_we",   lif.ram_we,   0);
      chk("ignored_addr", lif.ram_addr, 15);
      chk("ignored_data", lif.ram_data, 8'h1F);

      // reload from RUN with a gapped source
      load_image(8'h80, 3, 1'b1, 16, 8'h00);

      // reset mid-load after 7 bytes
      load_image(8'h40, 1, 1'b0, 7, 8'h00);
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      chk_reset_state("midclr");

      // CLR and start on the same edge: CLR wins
      CLR       = 1'b1;
      lif.start = 1'b1;
      step();
      CLR       = 1'b0;
      lif.start = 1'b0;
      step();
      chk("clr_start_ready", lif.in_ready, 0);
      chk("clr_start_hold",  lif.cpu_hold, 1);

      load_image(8'hC0, 1, 1'b0, 16, 8'h00);

      // start ignored while loading
      load_image(8'h20, 1, 1'b0, 3, 8'h00);
      lif.start    = 1'b1;
      lif.in_valid = 1'b1;
      lif.in_data  = 8'h55;
      step();
      lif.start    = 1'b0;
      lif.in_valid = 1'b0;
      chk("start_in_load_addr", lif.ram_addr, 3);
      chk("start_in_load_data", lif.ram_data, 8'h55);

`ifdef SAP1_LOADER_CHECKSUM_EN
      load_image(8'h01, 0, 1'b0, 16, 8'h00);
      load_image(8'h01, 0, 1'b0, 16, 8'h01);
      step();
      chk("err_hold", lif.error, 1);
      lif.start = 1'b1;
      step();
      lif.start = 1'b0;
      chk("err_cleared", lif.error,    0);
      chk("err_ready",   lif.in_ready, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
